alu_md_unit: RTL

//  Parametrised EX-stage ALU with built-in op/func decode plus an iterative unsigned

---
 rtl/alu_md_unit_if.sv | 28 ++
 rtl/alu_md_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_md_unit_if.sv
// Request/response bundle between the ID/EX register and the EX-stage ALU with
// its iterative multiply/divide unit.
interface alu_md_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [1:0]       op;
    logic [5:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             md_done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, op, func, a, b,
        input  ready, out_valid, result, zero, md_done, hi, lo
    );

    modport slave (
        input  in_valid, op, func, a, b,
        output ready, out_valid, result, zero, md_done, hi, lo
    );
endinterface

// File: rtl/alu_md_unit.sv
// EX-stage ALU with op/func decode, iterative shift-add MULTU and restoring DIVU into HI/LO.
// Define ALU_DIV_EN to compile in the divider; otherwise divu is a single-cycle op returning 0.
module alu_md_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_md_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
        OP_MFHI, OP_MFLO, OP_MULTU, OP_DIVU
    } alu_op_t;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t             r_state;
    state_t             w_state_next;
    alu_op_t            w_op;
    logic               w_accept;
    logic               w_is_md;
    logic               w_last;
    logic [WIDTH-1:0]   w_alu;

    logic               r_ready;
    logic               r_out_valid;
    logic               r_md_done;
    logic               r_zero;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_prod_next;

    function automatic logic [WIDTH-1:0] alu_calc(input alu_op_t op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_SLT:  return {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_MFHI: return hi;
            OP_MFLO: return lo;
            OP_DIVU: return '0;
            default: return a + b;
        endcase
    endfunction

    always_comb begin
        w_op = OP_ADD;
        case (bus.op)
            2'b00: w_op = OP_ADD;
            2'b01: w_op = OP_SUB;
            2'b10: w_op = OP_SLT;
            default: begin
                case (bus.func)
                    6'b100010: w_op = OP_SUB;
                    6'b100100: w_op = OP_AND;
                    6'b100101: w_op = OP_OR;
                    6'b101010: w_op = OP_SLT;
                    6'b010000: w_op = OP_MFHI;
                    6'b010010: w_op = OP_MFLO;
                    6'b011001: w_op = OP_MULTU;
                    6'b011011: w_op = OP_DIVU;
                    default:   w_op = OP_ADD;
                endcase
            end
        endcase
    end

    assign w_accept = bus.in_valid && r_ready;
    assign w_last   = (r_cnt == CNT_W'(1));
    assign w_alu    = alu_calc(w_op, bus.a, bus.b, r_hi, r_lo);

    always_comb begin
        w_is_md = (w_op == OP_MULTU);
`ifdef ALU_DIV_EN
        if (w_op == OP_DIVU) w_is_md = 1'b1;
`endif
    end

    // Shift-add step: conditionally add the multiplicand into the upper half, then shift right.
    assign w_add       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_next = {w_add, r_prod[WIDTH-1:1]};

`ifdef ALU_DIV_EN
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH:0]     w_rem_shift;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quot_next;

    // Restoring step: a borrow in w_diff means the trial subtraction is undone.
    assign w_rem_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_divisor};
    assign w_rem_next  = w_diff[WIDTH] ? w_rem_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quot_next = {r_quot[WIDTH-2:0], ~w_diff[WIDTH]};

    always_ff @(posedge clk) begin
        if (w_accept && (w_op == OP_DIVU)) begin
            r_divisor <= bus.b;
            r_quot    <= bus.a;
            r_rem     <= '0;
        end else if (r_state == S_DIV) begin
            r_quot    <= w_quot_next;
            r_rem     <= w_rem_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (w_accept && (w_op == OP_MULTU)) begin
            r_mcand <= bus.a;
            r_prod  <= {{WIDTH{1'b0}}, bus.b};
        end else if (r_state == S_MUL) begin
            r_prod  <= w_prod_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (w_op == OP_MULTU)) w_state_next = S_MUL;
`ifdef ALU_DIV_EN
                if (w_accept && (w_op == OP_DIVU))  w_state_next = S_DIV;
`endif
            end
            default: if (w_last) w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready     <= 1'b1;
            r_out_valid <= 1'b0;
            r_md_done   <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_hi        <= '0;
            r_lo        <= '0;
            r_cnt       <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_md_done   <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept && w_is_md) begin
                    r_ready <= 1'b0;
                    r_cnt   <= CNT_W'(WIDTH);
                end else if (w_accept) begin
                    r_out_valid <= 1'b1;
                    r_result    <= w_alu;
                    r_zero      <= (w_alu == '0);
                end
            end else begin
                r_cnt <= r_cnt - 1'b1;
                if (w_last) begin
                    r_ready   <= 1'b1;
                    r_md_done <= 1'b1;
                    if (r_state == S_MUL) begin
                        r_hi <= w_prod_next[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_next[WIDTH-1:0];
                    end
`ifdef ALU_DIV_EN
                    else begin
                        r_hi <= w_rem_next;
                        r_lo <= w_quot_next;
                    end
`endif
                end
            end
        end
    end

    assign bus.ready     = r_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.md_done   = r_md_done;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
endmodule
